// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine (FF46) and CPU/DMA arbiter sharing the single MMU port.
// Copies 160 bytes from page XX00 into FE00-FE9F while restricting the CPU to FF00-FFFF.
module oam_dma_arbiter #(
  parameter int unsigned BYTE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_wait,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active
);

  localparam int unsigned PH_W = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(BYTE_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_RD   = '0;
  localparam logic [PH_W-1:0] PH_WR   = PH_W'(2);
  localparam logic [7:0]      LAST_IDX = 8'd159;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [7:0]      idx_q, idx_d;
  logic [7:0]      src_page_q, src_page_d;
  logic [15:0]     mem_addr_q, mem_addr_d;
  logic [7:0]      mem_wdata_q, mem_wdata_d;
  logic            mem_rd_q, mem_rd_d;
  logic            mem_wr_q, mem_wr_d;
  logic            rd1_fwd_q, rd1_fwd_d;
  logic            rd1_int_q, rd1_int_d;
  logic [7:0]      rd1_val_q, rd1_val_d;
  logic            rd2_fwd_q, rd2_fwd_d;
  logic [7:0]      cpu_rdata_q, cpu_rdata_d;

  logic       cpu_req, hi_page, is_ff46, in_xfer, dma_slot;
  logic       grant, blocked, fwd;
  logic [7:0] src_eff;

  assign cpu_req  = cpu_rd | cpu_wr;
  assign hi_page  = (cpu_addr[15:8] == 8'hFF);
  assign is_ff46  = (cpu_addr == 16'hFF46);
  assign in_xfer  = (state_q == S_XFER);
  assign dma_slot = in_xfer && ((ph_q == PH_RD) || (ph_q == PH_WR));
  assign cpu_wait = cpu_req && hi_page && dma_slot;
  assign grant    = cpu_req && !cpu_wait;
  assign blocked  = in_xfer && !hi_page;
  assign fwd      = grant && !blocked && !is_ff46;
  assign src_eff  = (src_page_q >= 8'hE0) ? (src_page_q - 8'h20) : src_page_q;

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    idx_d       = idx_q;
    src_page_d  = src_page_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    rd1_fwd_d   = 1'b0;
    rd1_int_d   = 1'b0;
    rd1_val_d   = rd1_val_q;
    rd2_fwd_d   = rd1_fwd_q;
    cpu_rdata_d = cpu_rdata_q;
    if (rd1_int_q) cpu_rdata_d = rd1_val_q;
    if (rd2_fwd_q) cpu_rdata_d = mem_rdata;

    case (state_q)
      S_START: begin
        if (ph_q == PH_LAST) begin
          state_d = S_XFER;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_XFER: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (idx_q == LAST_IDX) state_d = S_IDLE;
          else                   idx_d   = idx_q + 8'd1;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = '0;
      end
    endcase

    // Strobes are registered: the read issued in ph 0 returns data during ph 2,
    // which is forwarded straight into the write issued in that same phase.
    if (in_xfer && (ph_q == PH_RD)) begin
      mem_rd_d   = 1'b1;
      mem_addr_d = {src_eff, idx_q};
    end else if (in_xfer && (ph_q == PH_WR)) begin
      mem_wr_d    = 1'b1;
      mem_addr_d  = {8'hFE, idx_q};
      mem_wdata_d = mem_rdata;
    end else if (fwd) begin
      mem_addr_d = cpu_addr;
      mem_rd_d   = cpu_rd;
      mem_wr_d   = cpu_wr;
      if (cpu_wr) mem_wdata_d = cpu_wdata;
    end

    if (grant && cpu_rd) begin
      if (fwd) begin
        rd1_fwd_d = 1'b1;
      end else begin
        rd1_int_d = 1'b1;
        rd1_val_d = is_ff46 ? src_page_q : 8'hFF;
      end
    end

    if (grant && cpu_wr && is_ff46) begin
      src_page_d = cpu_wdata;
      state_d    = S_START;
      ph_d       = '0;
      idx_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ph_q        <= '0;
      idx_q       <= '0;
      src_page_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      rd1_fwd_q   <= 1'b0;
      rd1_int_q   <= 1'b0;
      rd1_val_q   <= '0;
      rd2_fwd_q   <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      idx_q       <= idx_d;
      src_page_q  <= src_page_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      rd1_fwd_q   <= rd1_fwd_d;
      rd1_int_q   <= rd1_int_d;
      rd1_val_q   <= rd1_val_d;
      rd2_fwd_q   <= rd2_fwd_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign dma_active = (state_q != S_IDLE);
  // A forwarded read's data is passed through in its return cycle, then held.
  assign cpu_rdata  = rd2_fwd_q ? mem_rdata : cpu_rdata_q;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter with a one-cycle-latency MMU memory model.
module tb_oam_dma_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_rdata;
  logic        cpu_wait;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        dma_active;

  int checks = 0;
  int errors = 0;

  oam_dma_arbiter #(.BYTE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_rdata  (cpu_rdata),
    .cpu_wait   (cpu_wait),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_rdata  (mem_rdata),
    .dma_active (dma_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MMU model: writes land at the edge, read data appears the following cycle.
  logic [7:0] mem [0:65535];
  logic       model_ready = 1'b0;
  always @(posedge clk) begin
    if (!model_ready) begin
      for (int i = 0; i < 160; i++) begin
        mem[16'(16'hC100 + i)] <= 8'(i) ^ 8'h5A;
        mem[16'(16'hC200 + i)] <= 8'(i + 3);
        mem[16'(16'hC300 + i)] <= ~8'(i);
      end
      mem[16'hC001] <= 8'h34;
      mem[16'hC000] <= 8'h99;
      mem[16'hFF80] <= 8'h77;
      model_ready   <= 1'b1;
    end else begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= mem[mem_addr];
    end
  end

  int          cyc = 0;
  int          act_cnt = 0;
  int          viol = 0;
  int          c001_wr = 0;
  logic        prev_rd = 1'b0;
  logic        prev_wr = 1'b0;
  logic [15:0] wa[$];
  logic [7:0]  wd[$];
  int          wc[$];
  logic [15:0] ra[$];
  logic        dma_rd, dma_wr;

  assign dma_rd = mem_rd && (mem_addr[15:8] != 8'hFF);
  assign dma_wr = mem_wr && (mem_addr[15:8] == 8'hFE);

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (dma_active) act_cnt <= act_cnt + 1;
      if (dma_wr) begin
        wa.push_back(mem_addr);
        wd.push_back(mem_wdata);
        wc.push_back(cyc);
      end
      if (dma_rd && dma_active) ra.push_back(mem_addr);
      if (mem_wr && mem_addr == 16'hC001) c001_wr <= c001_wr + 1;
      if ((mem_rd && mem_wr) || (dma_rd && prev_rd) || (dma_wr && prev_wr)) viol <= viol + 1;
      prev_rd <= dma_rd;
      prev_wr <= dma_wr;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_xact(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [7:0] wdat, output logic [7:0] rdat, output int waits);
    @(negedge clk);
    cpu_addr  = addr;
    cpu_wdata = wdat;
    cpu_rd    = rd;
    cpu_wr    = wr;
    waits     = 0;
    #1;
    while (cpu_wait && waits < 16) begin
      waits++;
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    @(negedge clk);
    rdat = cpu_rdata;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (dma_active && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_eq(tag, 64'(dma_active), 64'd0);
  endtask

  task automatic wait_wr(input string tag, input logic [15:0] a);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      seen = mem_wr && (mem_addr == a);
      n++;
    end
    check_eq(tag, 64'(seen), 64'd1);
  endtask

  logic [7:0] rdat;
  int         waits;
  int         bw, ba, br, bad, n;

  initial begin
    rst_n = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", 64'({cpu_rdata, cpu_wait, mem_addr, mem_wdata, mem_rd, mem_wr, dma_active}), 64'd0);
    rst_n = 1'b1;

    cpu_xact(1'b1, 1'b0, 16'hC100, 8'h00, rdat, waits);
    check_eq("idle_read_c100", 64'(rdat), 64'h5A);
    cpu_xact(1'b1, 1'b0, 16'hFF46, 8'h00, rdat, waits);
    check_eq("ff46_reset_val", 64'(rdat), 64'h00);

    // Basic transfer with lockout and collision embedded.
    bw = wa.size(); ba = act_cnt;
    cpu_xact(1'b0, 1'b1, 16'hFF46, 8'hC1, rdat, waits);
    check_eq("start_waits", 64'(waits), 64'd0);
    check_eq("start_active", 64'(dma_active), 64'd1);
    repeat (20) @(negedge clk);
    cpu_xact(1'b1, 1'b0, 16'hC000, 8'h00, rdat, waits);
    check_eq("lock_read_ff", 64'(rdat), 64'hFF);
    check_eq("lock_read_wait", 64'(waits), 64'd0);
    cpu_xact(1'b0, 1'b1, 16'hC001, 8'h12, rdat, waits);
    check_eq("lock_write_wait", 64'(waits), 64'd0);
    wait_wr("coll_sync", 16'hFE08);
    cpu_xact(1'b1, 1'b0, 16'hFF80, 8'h00, rdat, waits);
    check_eq("coll_waits", 64'(waits), 64'd1);
    check_eq("coll_hram", 64'(rdat), 64'h77);
    wait_idle("basic_done");
    check_eq("basic_active_cycles", 64'(act_cnt - ba), 64'd644);
    n = wa.size() - bw;
    check_eq("basic_wr_count", 64'(n), 64'd160);
    bad = 0;
    for (int k = 0; k < n && k < 160; k++) begin
      if (wa[bw+k] != 16'(16'hFE00 + k) || wd[bw+k] != (8'(k) ^ 8'h5A)) bad++;
      if (k > 0 && (wc[bw+k] - wc[bw+k-1]) != 4) bad++;
    end
    check_eq("basic_wr_data_timing", 64'(bad), 64'd0);
    check_eq("lock_c001_mem", 64'(mem[16'hC001]), 64'h34);
    check_eq("lock_c001_wr", 64'(c001_wr), 64'd0);
    cpu_xact(1'b1, 1'b0, 16'hFF46, 8'h00, rdat, waits);
    check_eq("ff46_readback_c1", 64'(rdat), 64'hC1);

    // Restart after byte 50 written.
    bw = wa.size();
    cpu_xact(1'b0, 1'b1, 16'hFF46, 8'hC1, rdat, waits);
    wait_wr("restart_sync", 16'hFE32);
    cpu_xact(1'b0, 1'b1, 16'hFF46, 8'hC2, rdat, waits);
    check_eq("restart_waits", 64'(waits), 64'd1);
    wait_idle("restart_done");
    n = wa.size() - bw;
    check_eq("restart_wr_count", 64'(n), 64'd211);
    bad = 0;
    for (int k = 0; k < n && k < 211; k++) begin
      if (k < 51) begin
        if (wa[bw+k] != 16'(16'hFE00 + k) || wd[bw+k] != (8'(k) ^ 8'h5A)) bad++;
      end else begin
        if (wa[bw+k] != 16'(16'hFE00 + k - 51) || wd[bw+k] != 8'(k - 51 + 3)) bad++;
      end
    end
    check_eq("restart_wr_seq", 64'(bad), 64'd0);

    // Echo source page.
    bw = wa.size(); br = ra.size();
    cpu_xact(1'b0, 1'b1, 16'hFF46, 8'hE3, rdat, waits);
    wait_idle("echo_done");
    check_eq("echo_rd_count", 64'(ra.size() - br), 64'd160);
    check_eq("echo_first_rd", 64'(ra[br]), 64'hC300);
    check_eq("echo_last_rd", 64'(ra[br+159]), 64'hC39F);
    bad = 0;
    for (int k = 0; k < 160 && (bw + k) < wa.size(); k++)
      if (wd[bw+k] != ~8'(k)) bad++;
    check_eq("echo_wr_data", 64'(bad), 64'd0);

    // Reset mid-transfer.
    cpu_xact(1'b0, 1'b1, 16'hFF46, 8'hC1, rdat, waits);
    wait_wr("rst_sync", 16'hFE50);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_outs", 64'({cpu_rdata, cpu_wait, mem_addr, mem_wdata, mem_rd, mem_wr, dma_active}), 64'd0);
    repeat (3) @(negedge clk);
    bw = wa.size();
    rst_n = 1'b1;
    repeat (700) @(negedge clk);
    check_eq("midrst_no_wr", 64'(wa.size() - bw), 64'd0);
    cpu_xact(1'b1, 1'b0, 16'hFF46, 8'h00, rdat, waits);
    check_eq("midrst_ff46", 64'(rdat), 64'h00);
    bw = wa.size(); ba = act_cnt;
    cpu_xact(1'b0, 1'b1, 16'hFF46, 8'hC2, rdat, waits);
    wait_idle("clean_done");
    check_eq("clean_active_cycles", 64'(act_cnt - ba), 64'd644);
    n = wa.size() - bw;
    check_eq("clean_wr_count", 64'(n), 64'd160);
    bad = 0;
    for (int k = 0; k < n && k < 160; k++)
      if (wa[bw+k] != 16'(16'hFE00 + k) || wd[bw+k] != 8'(k + 3)) bad++;
    check_eq("clean_wr_data", 64'(bad), 64'd0);
    check_eq("strobe_rules", 64'(viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
